// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM state encoding and default width for alu_ac_unit    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int c_default_width = 16;

  localparam logic [3:0] c_op_pass = 4'd0;
  localparam logic [3:0] c_op_add  = 4'd1;
  localparam logic [3:0] c_op_sub  = 4'd2;
  localparam logic [3:0] c_op_and  = 4'd3;
  localparam logic [3:0] c_op_or   = 4'd4;
  localparam logic [3:0] c_op_xor  = 4'd5;
  localparam logic [3:0] c_op_not  = 4'd6;
  localparam logic [3:0] c_op_inc  = 4'd7;
  localparam logic [3:0] c_op_dec  = 4'd8;
  localparam logic [3:0] c_op_shl  = 4'd9;
  localparam logic [3:0] c_op_shr  = 4'd10;
  localparam logic [3:0] c_op_mul  = 4'd11;
  localparam logic [3:0] c_op_clr  = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_mul_seq : shift-add multiplier, one iteration per cycle, WIDTH cycles  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int                 c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_next;

  // product is the accumulator after the current iteration; complete when last is high
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
  assign product    = w_acc_next;
  assign last       = r_busy && (r_cnt == c_last_cnt);
  assign busy       = r_busy;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (last) begin
        r_busy <= 1'b0;
      end
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_ac_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_ac_unit : accumulator ALU with Z/C flags; MUL only with IAAA_ALU_MUL_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_ac_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A_BUS_in,
  input  logic [WIDTH-1:0] B_BUS_in,
  input  logic [3:0]       ALU_OP,
  input  logic             ALU_start,
  input  logic             AC_load,
  output logic [WIDTH-1:0] AC_out,
  output logic             Z_flag,
  output logic             C_flag,
  output logic             ALU_busy,
  output logic             ALU_done
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  alu_state_t       r_state;
  logic [WIDTH-1:0] r_ac;
  logic             r_z;
  logic             r_c;
  logic             r_done;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic             w_legal;
  logic             w_is_mul;

  always_comb begin
    w_res    = r_ac;
    w_sum    = '0;
    w_carry  = 1'b0;
    w_legal  = 1'b1;
    w_is_mul = 1'b0;
    case (ALU_OP)
      c_op_pass: w_res = A_BUS_in;
      c_op_add: begin
        w_sum   = {1'b0, A_BUS_in} + {1'b0, B_BUS_in};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      c_op_sub: begin
        w_res   = A_BUS_in - B_BUS_in;
        w_carry = (A_BUS_in < B_BUS_in);
      end
      c_op_and: w_res = A_BUS_in & B_BUS_in;
      c_op_or:  w_res = A_BUS_in | B_BUS_in;
      c_op_xor: w_res = A_BUS_in ^ B_BUS_in;
      c_op_not: w_res = ~A_BUS_in;
      c_op_inc: begin
        w_sum   = {1'b0, r_ac} + {1'b0, c_one};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      c_op_dec: begin
        w_res   = r_ac - c_one;
        w_carry = (r_ac == '0);
      end
      c_op_shl: begin
        w_res   = {A_BUS_in[WIDTH-2:0], 1'b0};
        w_carry = A_BUS_in[WIDTH-1];
      end
      c_op_shr: begin
        w_res   = {1'b0, A_BUS_in[WIDTH-1:1]};
        w_carry = A_BUS_in[0];
      end
      c_op_clr: w_res = '0;
`ifdef IAAA_ALU_MUL_EN
      c_op_mul: w_is_mul = 1'b1;
`endif
      default: w_legal = 1'b0;
    endcase
  end

`ifdef IAAA_ALU_MUL_EN
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_mul_product;

  assign w_mul_start = ALU_start && w_is_mul && (r_state == ST_IDLE);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .start   (w_mul_start),
    .a       (A_BUS_in),
    .b       (B_BUS_in),
    .busy    (w_mul_busy),
    .last    (w_mul_last),
    .product (w_mul_product)
  );

  assign ALU_busy = w_mul_busy;
`else
  assign ALU_busy = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_ac    <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // start wins over load; illegal ops still acknowledge with done
          if (ALU_start) begin
            if (w_is_mul) begin
              r_state <= ST_MUL;
            end else begin
              r_done <= 1'b1;
              if (w_legal) begin
                r_ac <= w_res;
                r_z  <= (w_res == '0);
                r_c  <= w_carry;
              end
            end
          end else if (AC_load) begin
            r_ac <= A_BUS_in;
          end
        end
`ifdef IAAA_ALU_MUL_EN
        ST_MUL: begin
          if (w_mul_last) begin
            r_ac    <= w_mul_product[WIDTH-1:0];
            r_z     <= (w_mul_product[WIDTH-1:0] == '0);
            r_c     <= |w_mul_product[2*WIDTH-1:WIDTH];
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign AC_out   = r_ac;
  assign Z_flag   = r_z;
  assign C_flag   = r_c;
  assign ALU_done = r_done;

endmodule
`default_nettype wire

// File: doc/alu_ac_unit.md
ALU_AC_UNIT -- requirements
Module: alu_ac_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 16, datapath width of A/B buses and AC.
REQ-002 SHALL have port: Clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port: Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: A_BUS_in  input  WIDTH  operand A, driven by the registered A-bus mux output.
REQ-005 SHALL have port: B_BUS_in  input  WIDTH  operand B from the B-bus mux.
REQ-006 SHALL have port: ALU_OP  input  4  operation code, sampled with ALU_start.
REQ-007 SHALL have port: ALU_start  input  1  one-cycle request to execute ALU_OP.
REQ-008 SHALL have port: AC_load  input  1  load AC from A_BUS_in with no flag update.
REQ-009 SHALL have port: AC_out  output  WIDTH  accumulator value, registered.
REQ-010 SHALL have port: Z_flag  output  1  last result equals zero.
REQ-011 SHALL have port: C_flag  output  1  carry/borrow/shift-out/multiply-overflow of last result.
REQ-012 SHALL have port: ALU_busy  output  1  high while a multi-cycle operation runs.
REQ-013 SHALL have port: ALU_done  output  1  one-cycle pulse on operation completion.

Function
REQ-014 SHALL implement FSM states IDLE and MUL; IDLE->MUL on ALU_start with op MUL; MUL->IDLE after 16 iterations.
REQ-015 SHALL decode ops: 0 PASS (AC=A), 1 ADD (A+B), 2 SUB (A-B), 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 INC (AC+1), 8 DEC (AC-1), 9 SHL A by 1, 10 SHR A (logical) by 1, 11 MUL (A*B), 12 CLR (AC=0).
REQ-016 SHALL, for single-cycle ops in IDLE, write AC and flags at the edge sampling ALU_start and pulse ALU_done in the next cycle.
REQ-017 SHALL set Z_flag to (result==0) for every executed op, including CLR (Z=1).
REQ-018 SHALL set C_flag: ADD/INC carry-out of bit WIDTH-1, SUB borrow (A<B unsigned), DEC borrow (AC==0), SHL old bit WIDTH-1, SHR old bit 0, MUL OR of product bits [2*WIDTH-1:WIDTH]; 0 for PASS, logic ops, CLR.
REQ-019 SHALL perform MUL as shift-add: latch A and B on start, one iteration per cycle, ALU_busy high exactly 16 cycles, AC = low WIDTH product bits at final edge, ALU_done pulse next cycle.
REQ-020 SHALL ignore ALU_start and AC_load while ALU_busy; AC and flags hold until MUL completes.
REQ-021 SHALL give ALU_start priority over AC_load when both asserted in IDLE.
REQ-022 SHALL treat ops 13-15 as illegal: AC and flags unchanged, ALU_done still pulses.
REQ-023 SHALL wrap arithmetic modulo 2^WIDTH (0xFFFF+1 = 0x0000, C=1).

Reset
REQ-024 SHALL, on Reset_n low, immediately force AC_out=0, Z_flag=0, C_flag=0, ALU_busy=0, ALU_done=0, state IDLE.
REQ-025 SHALL abort an in-progress MUL on reset with no ALU_done pulse and no AC update afterward.

Configuration
REQ-026 SHALL compile MUL support only when macro IAAA_ALU_MUL_EN is defined; without it op 11 behaves as illegal (REQ-022), MUL state and multiplier are absent, ALU_busy is constant 0.

Structure
REQ-027 SHALL place opcode constants, FSM state encoding and default WIDTH in shared package alu_pkg.
REQ-028 SHALL implement the shift-add multiplier as sub-module alu_mul_seq (start, busy, product) instantiated only under IAAA_ALU_MUL_EN.

Verification
REQ-029 SHALL cover: ADD A=0xFFFF B=0x0001 -> AC=0x0000, Z=1, C=1, ALU_done next cycle.
REQ-030 SHALL cover: SUB A=0x0003 B=0x0005 -> AC=0xFFFE, Z=0, C=1.
REQ-031 SHALL cover: MUL A=0x0100 B=0x0200 -> busy 16 cycles, AC=0x0000, C=1, Z=1; MUL A=7 B=6 -> AC=0x002A, C=0.
REQ-032 SHALL cover: ALU_start ADD and AC_load asserted during MUL -> both ignored, MUL result unchanged.
REQ-033 SHALL cover: Reset_n low at MUL cycle 8 -> AC=0, busy=0 at once; no ALU_done afterward.
REQ-034 SHALL cover: op 14 with AC=0x1234 -> AC=0x1234, flags unchanged, ALU_done pulses once.
